// File: rtl/decap_packet.sv
// Aurora RX decapsulator: strips the 9-bit beat header, checks beat sequencing and
// reassembles the 1034-bit DFX word {data, addr} from NUMBER_PACKET payload beats.
//
// state   | meaning
// IDLE    | waiting for a seq==0 beat to open a frame
// COLLECT | frame open; expecting beat cnt_q before the gap timer expires
module decap_packet #(
    parameter int DATA_WIDTH             = 1024,
    parameter int ADDR_WIDTH             = 10,
    parameter int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH,
    parameter int RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int NUMBER_PACKET          = 19,
    parameter int TTL_WIDTH              = 2,
    parameter int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + $clog2(NUMBER_PACKET) + TTL_WIDTH,
    parameter int AURORA_DATA_WIDTH      = 64,
    parameter int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH,
    parameter int TIMEOUT_CYCLES         = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [AURORA_DATA_WIDTH-1:0]      data_recv,
    input  logic                              data_recv_valid,
    output logic [DATA_DFX_WIDTH-1:0]         data_dfx_recv,
    output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
    output logic [TTL_WIDTH-1:0]              ttl_recv,
    output logic                              decap_done,
    output logic                              seq_err,
    output logic                              timeout_err,
    output logic                              busy
);

    localparam int SEQ_WIDTH    = $clog2(NUMBER_PACKET);
    localparam int SHADOW_WIDTH = (NUMBER_PACKET - 1) * PAYLOAD_WIDTH;
    localparam int LAST_WIDTH   = DATA_DFX_WIDTH - SHADOW_WIDTH;
    localparam int GAP_WIDTH    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SEQ_WIDTH-1:0] LAST_SEQ = SEQ_WIDTH'(NUMBER_PACKET - 1);
    localparam logic [GAP_WIDTH-1:0] GAP_LOAD = GAP_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                             state_q;
    logic [SEQ_WIDTH-1:0]               cnt_q;
    logic [GAP_WIDTH-1:0]               gap_q;
    logic [SHADOW_WIDTH-1:0]            shadow_q;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0]  rid_q;
    logic [TTL_WIDTH-1:0]               ttl_q;
    logic [DATA_DFX_WIDTH-1:0]          data_dfx_q;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0]  rid_out_q;
    logic [TTL_WIDTH-1:0]               ttl_out_q;
    logic                               done_q;
    logic                               seq_err_q;
    logic                               timeout_err_q;

    logic [RECOGNIZE_ROUTER_WIDTH-1:0]  hdr_rid;
    logic [SEQ_WIDTH-1:0]               hdr_seq;
    logic [TTL_WIDTH-1:0]               hdr_ttl;
    logic [PAYLOAD_WIDTH-1:0]           payload;

    logic start_d;
    logic accept_d;
    logic last_d;
    logic seq_err_d;
    logic timeout_d;

    assign hdr_rid = data_recv[HEADER_WIDTH-1 -: RECOGNIZE_ROUTER_WIDTH];
    assign hdr_seq = data_recv[TTL_WIDTH +: SEQ_WIDTH];
    assign hdr_ttl = data_recv[TTL_WIDTH-1:0];
    assign payload = data_recv[AURORA_DATA_WIDTH-1:HEADER_WIDTH];

    // A seq==0 beat always opens a frame; in COLLECT it also flags the abandoned one.
    always_comb begin
        start_d   = 1'b0;
        accept_d  = 1'b0;
        last_d    = 1'b0;
        seq_err_d = 1'b0;
        timeout_d = 1'b0;
        if (data_recv_valid) begin
            start_d  = (hdr_seq == '0);
            accept_d = (state_q == COLLECT) && (hdr_seq != '0) && (hdr_seq == cnt_q)
                       && (hdr_rid == rid_q) && (hdr_ttl == ttl_q);
            last_d   = accept_d && (cnt_q == LAST_SEQ);
            seq_err_d = !accept_d && !(start_d && (state_q == IDLE));
        end else begin
            timeout_d = (state_q == COLLECT) && (gap_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            gap_q         <= '0;
            shadow_q      <= '0;
            rid_q         <= '0;
            ttl_q         <= '0;
            data_dfx_q    <= '0;
            rid_out_q     <= '0;
            ttl_out_q     <= '0;
            done_q        <= 1'b0;
            seq_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            done_q        <= last_d;
            seq_err_q     <= seq_err_d;
            timeout_err_q <= timeout_d;
            if (start_d) begin
                shadow_q[PAYLOAD_WIDTH-1:0] <= payload;
                rid_q   <= hdr_rid;
                ttl_q   <= hdr_ttl;
                cnt_q   <= SEQ_WIDTH'(1);
                gap_q   <= GAP_LOAD;
                state_q <= COLLECT;
            end else if (last_d) begin
                // Final beat bypasses the shadow; its upper payload bits are padding.
                data_dfx_q <= {payload[LAST_WIDTH-1:0], shadow_q};
                rid_out_q  <= rid_q;
                ttl_out_q  <= ttl_q;
                cnt_q      <= '0;
                state_q    <= IDLE;
            end else if (accept_d) begin
                for (int k = 1; k < NUMBER_PACKET - 1; k++) begin
                    if (cnt_q == SEQ_WIDTH'(k)) begin
                        shadow_q[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= payload;
                    end
                end
                cnt_q <= cnt_q + SEQ_WIDTH'(1);
                gap_q <= GAP_LOAD;
            end else if (seq_err_d || timeout_d) begin
                cnt_q   <= '0;
                state_q <= IDLE;
            end else if (state_q == COLLECT) begin
                gap_q <= gap_q - GAP_WIDTH'(1);
            end
        end
    end

    assign data_dfx_recv  = data_dfx_q;
    assign router_id_recv = rid_out_q;
    assign ttl_recv       = ttl_out_q;
    assign decap_done     = done_q;
    assign seq_err        = seq_err_q;
    assign timeout_err    = timeout_err_q;
    assign busy           = (state_q == COLLECT);

endmodule

// File: tb/tb_decap_packet.sv
// Directed bench for decap_packet: clean frames, gaps, timeout, sequence errors,
// restart, back-to-back frames and mid-frame reset.
module tb_decap_packet;

    logic          clk;
    logic          rst;
    logic [63:0]   data_recv;
    logic          data_recv_valid;
    logic [1033:0] data_dfx_recv;
    logic [1:0]    router_id_recv;
    logic [1:0]    ttl_recv;
    logic          decap_done;
    logic          seq_err;
    logic          timeout_err;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cyc = 0;
    int first_done_cyc = 0;
    string tname = "";

    logic [1033:0] w1, w2, w3, w4, w5, w6, w7, w8, w9, w_ones, w_a5;

    decap_packet dut (
        .clk             (clk),
        .rst             (rst),
        .data_recv       (data_recv),
        .data_recv_valid (data_recv_valid),
        .data_dfx_recv   (data_dfx_recv),
        .router_id_recv  (router_id_recv),
        .ttl_recv        (ttl_recv),
        .decap_done      (decap_done),
        .seq_err         (seq_err),
        .timeout_err     (timeout_err),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s: got %h expected %h", tname, tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [1033:0] obs, input logic [1033:0] exp);
        logic [1087:0] o;
        logic [1087:0] e;
        int idx;
        o = {54'b0, obs};
        e = {54'b0, exp};
        idx = 0;
        for (int i = 16; i >= 0; i--) begin
            if (o[i*64 +: 64] !== e[i*64 +: 64]) idx = i;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s %s: chunk %0d got %h expected %h", tname, tag, idx, o[idx*64 +: 64], e[idx*64 +: 64]);
        end
    endtask

    function automatic logic [1033:0] mk(input logic [7:0] b, input logic [9:0] a);
        return {{128{b}}, a};
    endfunction

    // Beat k carries word bits [k*55 +: 55]; padding above bit 1033 must be ignored.
    task automatic send_beat(input logic [1033:0] w, input int k, input logic [1:0] rid,
                             input logic [1:0] ttl, input logic [4:0] seq);
        logic [1044:0] ext;
        ext = {11'h5A5, w};
        data_recv       = {ext[k*55 +: 55], rid, seq, ttl};
        data_recv_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        data_recv_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("idle%0d pulses", i), {decap_done, seq_err, timeout_err}, 3'b000);
        end
    endtask

    task automatic send_range(input logic [1033:0] w, input logic [1:0] rid, input logic [1:0] ttl,
                              input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            send_beat(w, k, rid, ttl, 5'(k));
            chk($sformatf("beat%0d pulses", k), {decap_done, seq_err, timeout_err},
                (k == 18) ? 3'b100 : 3'b000);
            chk($sformatf("beat%0d busy", k), busy, (k != 18));
            if (k == 18) begin
                chk_word("word", data_dfx_recv, w);
                chk("rid", router_id_recv, rid);
                chk("ttl", ttl_recv, ttl);
                done_cyc = cyc;
            end
        end
    endtask

    task automatic send_bad(input logic [1033:0] w, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            send_beat(w, k, 2'b10, 2'b01, 5'(k));
            chk($sformatf("stray%0d pulses", k), {decap_done, seq_err, timeout_err}, 3'b010);
            chk($sformatf("stray%0d busy", k), busy, 1'b0);
        end
    endtask

    initial begin
        logic [1151:0] pat;
        pat    = {9{128'h1111_2222_3333_4444_5555_6666_7777_8888}};
        w1     = pat[1033:0];
        w2     = ~w1;
        w3     = {w1[516:0], w1[1033:517]};
        w4     = w1 ^ mk(8'h3C, 10'h0F0);
        w5     = w2 ^ mk(8'h5A, 10'h155);
        w6     = w1 ^ mk(8'hC3, 10'h0F1);
        w7     = w3 ^ mk(8'h69, 10'h3FE);
        w8     = w2 ^ mk(8'h96, 10'h001);
        w9     = w3 ^ mk(8'h17, 10'h2C4);
        w_ones = '1;
        w_a5   = mk(8'hA5, 10'h2AA);

        rst = 1'b1;
        data_recv = '0;
        data_recv_valid = 1'b0;
        tname = "reset";
        tick();
        tick();
        chk_word("word", data_dfx_recv, '0);
        chk("rid", router_id_recv, 2'b00);
        chk("ttl", ttl_recv, 2'b00);
        chk("flags", {decap_done, seq_err, timeout_err, busy}, 4'b0000);
        rst = 1'b0;
        idle(1);

        tname = "t1 clean";
        send_range(w1, 2'b10, 2'b01, 0, 18);
        idle(1);
        chk_word("held", data_dfx_recv, w1);

        tname = "t2 gap5";
        send_range(w2, 2'b10, 2'b01, 0, 7);
        idle(5);
        chk("busy in gap", busy, 1'b1);
        send_range(w2, 2'b10, 2'b01, 8, 18);
        idle(1);

        tname = "t2 gap64";
        send_range(w3, 2'b10, 2'b01, 0, 7);
        data_recv_valid = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            chk($sformatf("gap%0d pulses", i), {decap_done, seq_err, timeout_err},
                (i == 64) ? 3'b001 : 3'b000);
            chk($sformatf("gap%0d busy", i), busy, (i < 64));
        end
        chk_word("unchanged", data_dfx_recv, w2);
        send_bad(w3, 8, 18);
        chk_word("unchanged2", data_dfx_recv, w2);
        idle(1);

        tname = "t2 gap63";
        send_range(w3, 2'b10, 2'b01, 0, 7);
        idle(63);
        send_range(w3, 2'b10, 2'b01, 8, 18);
        idle(1);

        tname = "t3 skip";
        send_range(w4, 2'b10, 2'b01, 0, 4);
        send_beat(w4, 5, 2'b10, 2'b01, 5'd6);
        chk("skip pulses", {decap_done, seq_err, timeout_err}, 3'b010);
        chk("skip busy", busy, 1'b0);
        send_bad(w4, 6, 18);
        chk_word("unchanged", data_dfx_recv, w3);
        idle(1);
        tname = "t3 clean";
        send_range(w5, 2'b01, 2'b10, 0, 18);
        idle(1);

        tname = "t3 ttl mismatch";
        send_range(w1, 2'b10, 2'b01, 0, 3);
        send_beat(w1, 4, 2'b10, 2'b10, 5'd4);
        chk("mm pulses", {decap_done, seq_err, timeout_err}, 3'b010);
        chk("mm busy", busy, 1'b0);
        idle(1);

        tname = "t4 restart";
        send_range(w6, 2'b10, 2'b01, 0, 9);
        send_beat(w7, 0, 2'b11, 2'b10, 5'd0);
        chk("restart pulses", {decap_done, seq_err, timeout_err}, 3'b010);
        chk("restart busy", busy, 1'b1);
        send_range(w7, 2'b11, 2'b10, 1, 18);
        idle(1);

        tname = "t5 b2b";
        send_range(w_ones, 2'b01, 2'b11, 0, 18);
        first_done_cyc = done_cyc;
        send_range(w_a5, 2'b10, 2'b00, 0, 18);
        chk("spacing", done_cyc - first_done_cyc, 19);
        idle(1);

        tname = "t6 reset";
        send_range(w8, 2'b10, 2'b01, 0, 11);
        rst = 1'b1;
        send_beat(w8, 12, 2'b10, 2'b01, 5'd12);
        rst = 1'b0;
        chk_word("word", data_dfx_recv, '0);
        chk("rid", router_id_recv, 2'b00);
        chk("ttl", ttl_recv, 2'b00);
        chk("flags", {decap_done, seq_err, timeout_err, busy}, 4'b0000);
        send_bad(w8, 13, 18);
        idle(1);
        tname = "t6 clean";
        send_range(w9, 2'b00, 2'b11, 0, 18);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decap_packet.md
Name: decap_packet

Overview:
- Receive-side counterpart of the packet encapsulator in input_port_0.
- Takes the 64-bit Aurora word stream; each word is {payload[54:0], header[8:0]}.
- Strips the header and checks beat sequencing.
- Reassembles the 1034-bit DFX word ({data, addr}) and presents it with one done pulse per frame.
- Sits between the Aurora RX user interface and the input-port buffer/write logic.

Parameters:
- DATA_WIDTH, 1024, DFX data bits
- ADDR_WIDTH, 10, DFX address bits
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH (1034), reassembled word width
- RECOGNIZE_ROUTER_WIDTH, 2, router-id field width
- NUMBER_PACKET, 19, beats per frame
- TTL_WIDTH, 2, TTL field width
- HEADER_WIDTH, RECOGNIZE_ROUTER_WIDTH+$clog2(NUMBER_PACKET)+TTL_WIDTH (9), header width
- AURORA_DATA_WIDTH, 64, link word width
- PAYLOAD_WIDTH, AURORA_DATA_WIDTH-HEADER_WIDTH (55), payload bits per beat
- TIMEOUT_CYCLES, 64, maximum idle cycles allowed between beats inside a frame

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- data_recv  in  AURORA_DATA_WIDTH  link word
- data_recv_valid  in  1  data_recv qualifier; no backpressure
- data_dfx_recv  out  DATA_DFX_WIDTH  reassembled DFX word
- router_id_recv  out  RECOGNIZE_ROUTER_WIDTH  router-id field of the completed frame
- ttl_recv  out  TTL_WIDTH  TTL field of the completed frame
- decap_done  out  1  one-cycle pulse; outputs valid
- seq_err  out  1  one-cycle pulse; frame aborted on sequence error
- timeout_err  out  1  one-cycle pulse; frame aborted on gap timeout
- busy  out  1  high while in COLLECT

Behaviour:
- Header layout (bits [8:0] of data_recv):
  - [8:7] router id
  - [6:2] sequence index, 0..18
  - [1:0] TTL
- Payload is data_recv[63:9].
- Beat k carries DFX bits [k*55 +: 55], LSB first.
- Beat 18 carries bits [1033:990] in its low 44 payload bits. The upper 11 payload bits of beat 18 are ignored.
- Reset (rst=1 at a clk edge):
  - state=IDLE, beat counter=0, gap counter=0.
  - data_dfx_recv, router_id_recv, ttl_recv = 0.
  - decap_done, seq_err, timeout_err, busy = 0.
  - Any partial frame is discarded. Reset has priority over all other events.
- State IDLE:
  - valid with seq==0: store payload into shadow[54:0]; latch router id and TTL; beat counter=1; go to COLLECT.
  - valid with seq!=0: seq_err pulse next cycle; stay in IDLE.
- State COLLECT:
  - valid with seq==counter: store into shadow[counter*55 +: 55]; counter+1; gap counter=0.
  - valid with router id or TTL different from the latched values: treated as seq_err.
  - valid with seq==0 (frame restarted): seq_err pulse; the beat opens a new frame (counter=1).
  - any other seq: seq_err pulse; go to IDLE; shadow discarded.
  - No valid: gap counter+1. When it reaches TIMEOUT_CYCLES: timeout_err pulse, go to IDLE.
- Completion:
  - On accepting beat NUMBER_PACKET-1, on the next edge: data_dfx_recv <= shadow with the final beat merged; router_id_recv and ttl_recv load; decap_done=1 for one cycle; go to IDLE.
  - Latency: decap_done is high in the cycle after the last beat is sampled.
  - Outputs hold until the next completion or reset. They never change on an error.
- Back-to-back frames: a seq==0 beat arriving in the cycle that decap_done is high is accepted with no gap.
- The error and done pulses are mutually exclusive in any cycle.
- The shadow register is separate from data_dfx_recv, so a new frame can start while the previous output is held.

Test Plan:
1. Reset, then 19 consecutive beats carrying data_dfx = 1034'h1111...8888 pattern, header 9'b10_sssss_01 (s=0..18):
   - decap_done pulses once, 1 cycle after beat 18.
   - data_dfx_recv matches the source word; router_id_recv=2'b10; ttl_recv=2'b01.
2. Same frame with data_recv_valid dropped for 5 cycles between beats 7 and 8:
   - correct reassembly, no error.
   - Repeat with a 64-cycle gap: timeout_err pulses, no decap_done, data_dfx_recv unchanged.
3. Beat 5 sent with seq=6:
   - seq_err pulses, busy falls, and the remaining beats cause seq_err pulses in IDLE.
   - A following clean frame completes correctly.
4. Frame restarted at beat 10 with seq=0:
   - seq_err pulses and the new 19-beat frame completes with its own data.
5. Two back-to-back frames with different data (all-ones, then 0xA5 pattern + 10'h2AA):
   - two decap_done pulses 19 cycles apart, each with the correct word.
6. rst asserted at beat 12:
   - all outputs 0 next cycle.
   - Subsequent beats 13..18 give seq_err, then a clean frame completes.
